// File: rtl/csi2_pkg.sv
// Shared types and helpers for the CSI-2 packet to AXI4-Stream converter.
// Header layout, tuser layout, FSM states and the tkeep mask generator.
package csi2_pkg;

  localparam logic [5:0]  DT_LONG_MIN = 6'h10;
  localparam int unsigned HDR_DT_LSB  = 0;
  localparam int unsigned HDR_VC_LSB  = 6;
  localparam int unsigned HDR_WC_LSB  = 8;
  localparam int unsigned HDR_BYTES   = 4;
  localparam int unsigned MAX_BYTES   = 8;

  typedef struct packed {
    logic       sop;
    logic       err;
    logic       short_pkt;
    logic [5:0] dt;
    logic [1:0] vc;
  } csi2_tuser_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAYLOAD  = 2'd1,
    ST_DROP     = 2'd2,
    ST_DISABLED = 2'd3
  } csi2_state_e;

  // rem counts payload plus the two trailing CRC bytes; CRC never gets a keep bit.
  function automatic logic [MAX_BYTES-1:0] csi2_keep_mask(input logic [16:0] rem,
                                                          input int unsigned data_bytes,
                                                          input int unsigned offset);
    logic [MAX_BYTES-1:0] mask;
    logic [31:0]          rem32;
    logic [31:0]          avail;
    logic [31:0]          n;
    mask  = '0;
    rem32 = {15'd0, rem};
    avail = data_bytes - offset;
    n     = '0;
    if (rem32 > 32'd2) begin
      n = ((rem32 - 32'd2) > avail) ? avail : (rem32 - 32'd2);
    end
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if ((i >= offset) && (i < offset + n)) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; the converter has no backpressure so tready is not carried.
interface axi4_stream_if #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned USER_W     = 11
);
  logic                    tvalid;
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic [USER_W-1:0]       tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser);
  modport slave  (input  tvalid, tdata, tkeep, tlast, tuser);
endinterface

// File: rtl/csi2_sat_cnt.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module csi2_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/csi2_to_axi4_stream_gen2.sv
// CSI-2 packet to AXI4-Stream converter: strips headers onto tuser, trims CRC via
// tkeep, filters virtual channels, terminates on errors and requests PHY resync.
module csi2_to_axi4_stream_gen2
  import csi2_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [3:0]  VC_MASK    = 4'b1111,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    enable_i,
  input  logic [8*DATA_BYTES-1:0] data_i,
  input  logic                    valid_i,
  input  logic                    error_i,
  output logic                    phy_rst_o,
  axi4_stream_if.master           pkt_o,
  output logic [CNT_W-1:0]        pkt_cnt_o,
  output logic [CNT_W-1:0]        err_cnt_o
);

  localparam int unsigned HDR_OFF = (DATA_BYTES == 8) ? HDR_BYTES : 0;

  csi2_state_e state_q, state_d;
  logic [16:0] rem_q, rem_d;
  logic        valid_d1;
  logic        sop_q, sop_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;

  logic                    beat_valid;
  logic                    beat_last;
  logic [8*DATA_BYTES-1:0] beat_data;
  logic [DATA_BYTES-1:0]   beat_keep;
  csi2_tuser_t             beat_user;
  logic                    pkt_inc;
  logic                    err_inc;

  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic [16:0] hdr_rem;
  logic        hdr_short;
  logic        hdr_vc_ok;
  logic        hdr_acc;

  assign hdr_dt    = data_i[HDR_DT_LSB +: 6];
  assign hdr_vc    = data_i[HDR_VC_LSB +: 2];
  assign hdr_wc    = data_i[HDR_WC_LSB +: 16];
  assign hdr_rem   = {1'b0, hdr_wc} + 17'd2;
  assign hdr_short = (hdr_dt < DT_LONG_MIN);
  assign hdr_vc_ok = VC_MASK[hdr_vc];
  assign hdr_acc   = (state_q == ST_IDLE) && valid_i && !valid_d1 && !error_i;

  logic                    in_hdr;
  int unsigned             w_off;
  logic [16:0]             w_rem;
  logic [16:0]             w_avail;
  logic [16:0]             w_rem_next;
  logic [DATA_BYTES-1:0]   w_mask;
  logic [8*DATA_BYTES-1:0] w_data;
  logic                    w_first;
  logic                    w_last;
  logic                    w_tlast;
  logic                    w_emit;

  // One word-accounting path serves payload words and, at 8 bytes, the upper half of the header word.
  always_comb begin
    in_hdr     = (state_q == ST_IDLE);
    w_rem      = in_hdr ? hdr_rem : rem_q;
    w_off      = in_hdr ? HDR_OFF : 0;
    w_avail    = 17'(DATA_BYTES - w_off);
    w_first    = in_hdr | sop_q;
    w_mask     = DATA_BYTES'(csi2_keep_mask(w_rem, DATA_BYTES, w_off));
    w_last     = (w_rem <= w_avail);
    // A zero-length packet still needs a lone tlast beat, recognised by rem<=2 before any beat.
    w_tlast    = (w_rem <= w_avail + 17'd2) && ((|w_mask) || ((w_rem <= 17'd2) && w_first));
    w_emit     = (|w_mask) || w_tlast;
    w_rem_next = w_last ? '0 : (w_rem - w_avail);
    w_data     = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      w_data[8*i +: 8] = w_mask[i] ? data_i[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sop_d      = sop_q;
    vc_d       = vc_q;
    dt_d       = dt_q;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    beat_data  = '0;
    beat_keep  = '0;
    beat_user  = '0;
    pkt_inc    = 1'b0;
    err_inc    = 1'b0;
    phy_rst_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hdr_acc) begin
          vc_d = hdr_vc;
          dt_d = hdr_dt;
          if (hdr_short) begin
            phy_rst_o = 1'b1;
            if (hdr_vc_ok) begin
              beat_valid      = 1'b1;
              beat_last       = 1'b1;
              beat_data[15:0] = hdr_wc;
              beat_keep[1:0]  = 2'b11;
              beat_user       = '{sop: 1'b1, err: 1'b0, short_pkt: 1'b1, dt: hdr_dt, vc: hdr_vc};
              pkt_inc         = 1'b1;
            end
          end else begin
            rem_d   = hdr_rem;
            sop_d   = 1'b1;
            state_d = hdr_vc_ok ? ST_PAYLOAD : ST_DROP;
            if (DATA_BYTES == 8) begin
              rem_d = w_rem_next;
              if (hdr_vc_ok && w_emit) begin
                beat_valid = 1'b1;
                beat_last  = w_tlast;
                beat_data  = w_data;
                beat_keep  = w_mask;
                beat_user  = '{sop: 1'b1, err: 1'b0, short_pkt: 1'b0, dt: hdr_dt, vc: hdr_vc};
                sop_d      = 1'b0;
              end
              if (w_last) begin
                phy_rst_o = 1'b1;
                pkt_inc   = hdr_vc_ok;
                state_d   = enable_i ? ST_IDLE : ST_DISABLED;
              end
            end
          end
        end else begin
          if (valid_i && error_i) begin
            phy_rst_o = 1'b1;
            err_inc   = 1'b1;
          end
          if (!enable_i) begin
            state_d = ST_DISABLED;
          end
        end
      end
      ST_PAYLOAD, ST_DROP: begin
        if (valid_i) begin
          if (error_i) begin
            phy_rst_o = 1'b1;
            err_inc   = 1'b1;
            rem_d     = '0;
            state_d   = ST_IDLE;
            if (state_q == ST_PAYLOAD) begin
              beat_valid = 1'b1;
              beat_last  = 1'b1;
              beat_user  = '{sop: sop_q, err: 1'b1, short_pkt: 1'b0, dt: dt_q, vc: vc_q};
            end
          end else begin
            rem_d = w_rem_next;
            if ((state_q == ST_PAYLOAD) && w_emit) begin
              beat_valid = 1'b1;
              beat_last  = w_tlast;
              beat_data  = w_data;
              beat_keep  = w_mask;
              beat_user  = '{sop: sop_q, err: 1'b0, short_pkt: 1'b0, dt: dt_q, vc: vc_q};
              sop_d      = 1'b0;
            end
            if (w_last) begin
              phy_rst_o = 1'b1;
              pkt_inc   = (state_q == ST_PAYLOAD);
              state_d   = enable_i ? ST_IDLE : ST_DISABLED;
            end
          end
        end
      end
      ST_DISABLED: begin
        phy_rst_o = 1'b1;
        if (enable_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      valid_d1     <= 1'b0;
      sop_q        <= 1'b0;
      vc_q         <= '0;
      dt_q         <= '0;
      pkt_o.tvalid <= 1'b0;
      pkt_o.tdata  <= '0;
      pkt_o.tkeep  <= '0;
      pkt_o.tlast  <= 1'b0;
      pkt_o.tuser  <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      valid_d1     <= valid_i;
      sop_q        <= sop_d;
      vc_q         <= vc_d;
      dt_q         <= dt_d;
      pkt_o.tvalid <= beat_valid;
      pkt_o.tdata  <= beat_data;
      pkt_o.tkeep  <= beat_keep;
      pkt_o.tlast  <= beat_last;
      pkt_o.tuser  <= beat_user;
    end
  end

  csi2_sat_cnt #(.WIDTH(CNT_W)) u_pkt_cnt (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .inc    (pkt_inc),
    .clear  (1'b0),
    .cnt    (pkt_cnt_o)
  );

  csi2_sat_cnt #(.WIDTH(CNT_W)) u_err_cnt (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .inc    (err_inc),
    .clear  (1'b0),
    .cnt    (err_cnt_o)
  );

endmodule
